// File: rtl/sensor_tx_scheduler_pkg.sv
// rtl/sensor_tx_scheduler_pkg.sv - shared types and constants for the sensor TX scheduler
//
// Purpose: state encoding, default tag base, frame counter width and an
//          elaboration-time clog2 helper used to size the source index.
// Ports:   none (package).
package sensor_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND_TAG  = 2'd1,
        S_SEND_DATA = 2'd2
    } sched_state_t;

    localparam int TAG_BASE_DEFAULT = 97;
    localparam int CNT_W            = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sensor_tx_scheduler_arbiter.sv
// rtl/sensor_tx_scheduler_arbiter.sv - combinational rotate-priority round-robin search
//
// Purpose: picks the first requesting source starting one past the last grant,
//          wrapping modulo N_SRC.
// Ports:   i_req         - request vector, one bit per source
//          i_last_grant  - index granted most recently
//          o_grant_valid - at least one request present
//          o_grant_idx   - winning source index (0 when no request)
module sensor_rr_arbiter
    import sensor_tx_scheduler_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int IDX_W = clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] w_cand;

    // Candidates are visited in priority order; the first hit wins and later
    // hits are ignored, so the last grant itself has the lowest priority.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            w_cand = IDX_W'((int'(i_last_grant) + i) % N_SRC);
            if (!o_grant_valid && i_req[w_cand]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/sensor_tx_scheduler.sv
// rtl/sensor_tx_scheduler.sv - round-robin sharing of one UART TX channel between sensor FIFOs
//
// Purpose: each grant pops one byte from the winning FIFO and emits a two-byte
//          frame (tag = TAG_BASE + source index, then the data byte).
// Ports:   i_clk, i_rst    - clock, asynchronous active-high reset
//          i_src_valid     - per-source FIFO not empty
//          i_src_data      - per-source head byte, source k at [k*DATA_DEPTH +: DATA_DEPTH]
//          o_src_pop       - one-cycle pop pulse to the granted FIFO
//          i_enable_mask   - per-source eligibility
//          o_tx_data/o_tx_valid/i_tx_ready - byte handshake towards UART TX
//          o_busy          - frame in progress
//          o_grant_idx     - current/last granted source
//          o_frames_sent   - completed frame count (wraps)
module sensor_tx_scheduler
    import sensor_tx_scheduler_pkg::*;
#(
    parameter int DATA_DEPTH = 8,
    parameter int N_SRC      = 8,
    parameter int TAG_BASE   = TAG_BASE_DEFAULT,
    parameter int IDX_W      = clog2(N_SRC)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_SRC-1:0]            i_src_valid,
    input  logic [N_SRC*DATA_DEPTH-1:0] i_src_data,
    output logic [N_SRC-1:0]            o_src_pop,
    input  logic [N_SRC-1:0]            i_enable_mask,
    output logic [DATA_DEPTH-1:0]       o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_busy,
    output logic [IDX_W-1:0]            o_grant_idx,
    output logic [CNT_W-1:0]            o_frames_sent
);

    localparam logic [DATA_DEPTH-1:0] TAG_BYTE = DATA_DEPTH'(TAG_BASE);

    sched_state_t          r_state;
    logic [IDX_W-1:0]      r_last_grant;
    logic [DATA_DEPTH-1:0] r_data;
    logic [CNT_W-1:0]      r_frames_sent;

    logic [N_SRC-1:0]      w_req;
    logic                  w_grant_valid;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [DATA_DEPTH-1:0] w_win_data;

    assign w_req         = i_src_valid & i_enable_mask;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frames_sent = r_frames_sent;

    sensor_rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_win_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_grant_idx == IDX_W'(k)) begin
                w_win_data = i_src_data[k*DATA_DEPTH +: DATA_DEPTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= IDX_W'(N_SRC - 1);
            r_data        <= '0;
            r_frames_sent <= '0;
            o_src_pop     <= '0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_grant_idx   <= '0;
        end else begin
            o_src_pop <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        // The data byte is captured here because the FIFO head
                        // may change as soon as the pop pulse lands.
                        r_data      <= w_win_data;
                        o_grant_idx <= w_grant_idx;
                        o_tx_data   <= TAG_BYTE + DATA_DEPTH'(w_grant_idx);
                        o_tx_valid  <= 1'b1;
                        o_src_pop   <= N_SRC'(1) << w_grant_idx;
                        r_state     <= S_SEND_TAG;
                    end else begin
                        o_tx_valid  <= 1'b0;
                    end
                end
                S_SEND_TAG: begin
                    if (i_tx_ready) begin
                        o_tx_data <= r_data;
                        r_state   <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    if (i_tx_ready) begin
                        o_tx_valid    <= 1'b0;
                        r_last_grant  <= o_grant_idx;
                        r_frames_sent <= r_frames_sent + CNT_W'(1);
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// tb/tb_sensor_tx_scheduler.sv - scoreboard bench for sensor_tx_scheduler
module tb_sensor_tx_scheduler;

    localparam int N = 8;
    localparam int W = 8;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [N-1:0]   i_src_valid;
    logic [N*W-1:0] i_src_data;
    logic [N-1:0]   o_src_pop;
    logic [N-1:0]   i_enable_mask = '1;
    logic [W-1:0]   o_tx_data;
    logic           o_tx_valid;
    logic           i_tx_ready = 1'b1;
    logic           o_busy;
    logic [2:0]     o_grant_idx;
    logic [15:0]    o_frames_sent;

    always #5 i_clk = ~i_clk;

    sensor_tx_scheduler #(
        .DATA_DEPTH (W),
        .N_SRC      (N),
        .TAG_BASE   (97),
        .IDX_W      (3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_src_valid   (i_src_valid),
        .i_src_data    (i_src_data),
        .o_src_pop     (o_src_pop),
        .i_enable_mask (i_enable_mask),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_busy        (o_busy),
        .o_grant_idx   (o_grant_idx),
        .o_frames_sent (o_frames_sent)
    );

    // Source FIFO models: stimulus advances wr_ptr, monitor advances rd_ptr on pops.
    logic [7:0] src_mem [N][16];
    logic [3:0] wr_ptr [N] = '{default: 4'd0};
    logic [3:0] rd_ptr [N] = '{default: 4'd0};
    int         pop_cnt [N] = '{default: 0};

    for (genvar g = 0; g < N; g++) begin : g_src
        assign i_src_valid[g]      = (wr_ptr[g] != rd_ptr[g]);
        assign i_src_data[g*W +: W] = src_mem[g][rd_ptr[g]];
    end

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];
    int         acc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int k, input logic [7:0] b);
        src_mem[k][wr_ptr[k]] = b;
        wr_ptr[k] = wr_ptr[k] + 4'd1;
    endtask

    task automatic expect_frame(input int k, input logic [7:0] b);
        exp_q.push_back(8'(97 + k));
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge i_clk); #1;
            n++;
        end while ((exp_q.size() != 0 || o_busy) && n < 300);
        check(tag, (exp_q.size() == 0 && !o_busy), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge i_clk); #1;
            n++;
        end while (!o_tx_valid && n < 50);
        check(tag, o_tx_valid, 1);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst) begin
            if (o_src_pop != '0) begin
                check("pop_onehot", $onehot(o_src_pop), 1);
                for (int k = 0; k < N; k++) begin
                    if (o_src_pop[k]) begin
                        check("pop_src_valid", i_src_valid[k], 1);
                        pop_cnt[k]++;
                        rd_ptr[k] = rd_ptr[k] + 4'd1;
                    end
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                acc_q.push_back(cyc);
                if (exp_q.size() == 0) check("tx_queue_nonempty", exp_q.size(), 1);
                else                   check("tx_byte", o_tx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_src_pop", o_src_pop, 0);
        check("rst_busy", o_busy, 0);
        check("rst_grant_idx", o_grant_idx, 0);
        check("rst_frames", o_frames_sent, 0);
        i_rst = 1'b0;

        // Fairness: every source has two bytes, ready held high.
        acc_q.delete();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < N; k++) begin
                expect_frame(k, 8'(16 * k + j));
                load(k, 8'(16 * k + j));
            end
        wait_idle("fair_done");
        check("fair_accepts", acc_q.size(), 32);
        for (int i = 1; i < acc_q.size(); i++)
            check("fair_spacing", acc_q[i] - acc_q[i-1], (i % 2 == 1) ? 1 : 2);
        check("fair_frames", o_frames_sent, 16);
        check("fair_grant_idx", o_grant_idx, 7);
        check("fair_pop_src0", pop_cnt[0], 2);

        // Single source.
        expect_frame(2, 8'h5A);
        load(2, 8'h5A);
        wait_idle("single_done");
        check("single_pop_src2", pop_cnt[2], 3);
        check("single_frames", o_frames_sent, 17);

        // Backpressure with a second byte waiting in the same source.
        i_tx_ready = 1'b0;
        p = pop_cnt[1];
        expect_frame(1, 8'hB1);
        expect_frame(1, 8'hB2);
        load(1, 8'hB1);
        load(1, 8'hB2);
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            check("bp_valid_held", o_tx_valid, 1);
            check("bp_tag_held", o_tx_data, 8'd98);
        end
        check("bp_single_pop", pop_cnt[1], p + 1);
        i_tx_ready = 1'b1;
        wait_idle("bp_done");
        check("bp_frames", o_frames_sent, 19);

        // Mask: only source 5 eligible, then masked off mid-frame.
        i_enable_mask = 8'h20;
        p = pop_cnt[0];
        expect_frame(5, 8'hC5);
        load(0, 8'hC0);
        load(5, 8'hC5);
        load(5, 8'hC6);
        wait_valid("mask_valid");
        i_enable_mask = 8'h00;
        wait_idle("mask_done");
        repeat (5) @(posedge i_clk);
        #1;
        check("mask_idle_valid", o_tx_valid, 0);
        check("mask_no_pop_src0", pop_cnt[0], p);
        check("mask_frames", o_frames_sent, 20);
        i_enable_mask = 8'hFF;
        expect_frame(0, 8'hC0);
        expect_frame(5, 8'hC6);
        wait_idle("mask_drain");
        check("mask_drain_frames", o_frames_sent, 22);

        // Reset while the data byte is pending.
        i_tx_ready = 1'b0;
        expect_frame(4, 8'h44);
        load(4, 8'h44);
        wait_valid("rstf_valid");
        i_tx_ready = 1'b1;
        @(posedge i_clk); #1;
        i_tx_ready = 1'b0;
        check("rstf_data_phase", o_tx_data, 8'h44);
        check("rstf_pending", exp_q.size(), 1);
        i_rst = 1'b1;
        #1;
        exp_q.delete();
        check("rstf_tx_valid", o_tx_valid, 0);
        check("rstf_busy", o_busy, 0);
        check("rstf_frames", o_frames_sent, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_tx_ready = 1'b1;
        expect_frame(0, 8'hA0);
        expect_frame(3, 8'hA3);
        load(3, 8'hA3);
        load(0, 8'hA0);
        wait_idle("rstf_after");
        check("rstf_after_frames", o_frames_sent, 2);

        // Counter wrap via preload.
        force dut.r_frames_sent = 16'hFFFE;
        #1;
        release dut.r_frames_sent;
        expect_frame(6, 8'hE1);
        load(6, 8'hE1);
        wait_idle("wrap_first");
        check("wrap_ffff", o_frames_sent, 16'hFFFF);
        expect_frame(6, 8'hE2);
        load(6, 8'hE2);
        wait_idle("wrap_second");
        check("wrap_zero", o_frames_sent, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
